// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller: FSM encoding,
// clear-timeout counter width and the fixed-priority picker.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    localparam int CNT_W   = 8;
    localparam int MAX_SRC = 16;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [3:0] lowest_set(input logic [MAX_SRC-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_sync_2ff.sv
// Two-flop synchronizer bank used on the source lines when IRQ_CTRL_SYNC_EN
// is defined.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt receiver / acknowledge engine: latches source edges, presents the
// highest-priority enabled one to the CPU and holds a clear back to the source.
// Optional input synchronizer: define IRQ_CTRL_SYNC_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int ID_W        = 2,
    parameter int CLR_TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_src_irq,
    input  logic [NUM_SRC-1:0] i_mask,
    input  logic               i_cpu_ack,
    output logic               o_cpu_irq,
    output logic [ID_W-1:0]    o_irq_id,
    output logic [NUM_SRC-1:0] o_irq_clear,
    output logic [NUM_SRC-1:0] o_pending,
    output logic               o_busy,
    output logic               o_clr_err
);

    logic [NUM_SRC-1:0] src_s, src_q, rise, avail, pend_clr;
    state_t             state, state_n;
    logic [ID_W-1:0]    id_n;
    logic               irq_n, err_n;
    logic [NUM_SRC-1:0] clr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

`ifdef IRQ_CTRL_SYNC_EN
    sync_2ff #(.WIDTH(NUM_SRC)) u_sync (
        .clk (i_clk),
        .rst (i_rst),
        .d   (i_src_irq),
        .q   (src_s)
    );
`else
    assign src_s = i_src_irq;
`endif

    assign rise   = src_s & ~src_q;
    assign avail  = o_pending & i_mask;
    assign o_busy = (state != ST_IDLE);

    always_comb begin
        state_n  = state;
        id_n     = o_irq_id;
        irq_n    = o_cpu_irq;
        clr_n    = o_irq_clear;
        cnt_n    = cnt;
        err_n    = o_clr_err;
        pend_clr = '0;
        case (state)
            ST_IDLE: begin
                if (|avail) begin
                    id_n    = ID_W'(lowest_set(MAX_SRC'(avail)));
                    irq_n   = 1'b1;
                    state_n = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // Ack wins over a simultaneous mask fall.
                if (i_cpu_ack) begin
                    pend_clr[o_irq_id] = 1'b1;
                    clr_n   = NUM_SRC'(1) << o_irq_id;
                    cnt_n   = CNT_W'(CLR_TIMEOUT);
                    irq_n   = 1'b0;
                    state_n = ST_CLEAR;
                end else if (!i_mask[o_irq_id]) begin
                    irq_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (!src_s[o_irq_id]) begin
                    clr_n   = '0;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else if (cnt <= CNT_W'(1)) begin
                    // Last permitted clear cycle and the source is still high.
                    clr_n   = '0;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            src_q       <= '0;
            o_pending   <= '0;
            o_irq_id    <= '0;
            o_cpu_irq   <= 1'b0;
            o_irq_clear <= '0;
            cnt         <= '0;
            o_clr_err   <= 1'b0;
        end else begin
            state       <= state_n;
            src_q       <= src_s;
            o_pending   <= (o_pending & ~pend_clr) | rise;
            o_irq_id    <= id_n;
            o_cpu_irq   <= irq_n;
            o_irq_clear <= clr_n;
            cnt         <= cnt_n;
            o_clr_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (CLR_TIMEOUT=5); latencies shift by 2 cycles
// when IRQ_CTRL_SYNC_EN is defined.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk, rst, ack;
    logic [3:0] src, mask;
    logic       cpu_irq, busy, clr_err;
    logic [1:0] irq_id;
    logic [3:0] irq_clear, pending;
    int         n_chk, n_err;

    irq_ctrl #(.NUM_SRC(4), .ID_W(2), .CLR_TIMEOUT(5)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_src_irq   (src),
        .i_mask      (mask),
        .i_cpu_ack   (ack),
        .o_cpu_irq   (cpu_irq),
        .o_irq_id    (irq_id),
        .o_irq_clear (irq_clear),
        .o_pending   (pending),
        .o_busy      (busy),
        .o_clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b1; src = '0; mask = 4'hF; ack = 1'b0;
        tick(2);
        chk("rst_irq", cpu_irq, 0);
        chk("rst_pend", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clr", irq_clear, 0);
        chk("rst_err", clr_err, 0);
        rst = 1'b0;
        tick(2);

        // single source
        src = 4'b0100;
        tick(1 + SL);
        chk("s_pend", pending, 4'b0100);
        chk("s_irq_early", cpu_irq, 0);
        tick(1);
        chk("s_irq", cpu_irq, 1);
        chk("s_id", irq_id, 2);
        chk("s_busy", busy, 1);
        tick(2);
        chk("s_id_stable", irq_id, 2);
        pulse_ack();
        chk("s_ack_irq", cpu_irq, 0);
        chk("s_ack_clr", irq_clear, 4'b0100);
        chk("s_ack_pend", pending, 0);
        tick(1);
        chk("s_clr_hold", irq_clear, 4'b0100);
        src = 4'b0000;
        tick(1 + SL);
        chk("s_clr_drop", irq_clear, 0);
        chk("s_idle", busy, 0);
        chk("s_no_err", clr_err, 0);

        // priority: 1 before 3, 3 presented without a second edge
        src = 4'b1010;
        tick(1 + SL);
        chk("p_pend", pending, 4'b1010);
        tick(1);
        chk("p_id1", irq_id, 1);
        chk("p_irq1", cpu_irq, 1);
        pulse_ack();
        chk("p_clr1", irq_clear, 4'b0010);
        chk("p_pend1", pending, 4'b1000);
        src = 4'b1000;
        tick(1 + SL);
        chk("p_clr1_drop", irq_clear, 0);
        chk("p_gap", cpu_irq, 0);
        tick(1);
        chk("p_irq3", cpu_irq, 1);
        chk("p_id3", irq_id, 3);
        pulse_ack();
        chk("p_clr3", irq_clear, 4'b1000);
        src = 4'b0000;
        tick(1 + SL);
        chk("p_done_busy", busy, 0);
        chk("p_done_pend", pending, 0);

        // mask withdrawal before ack
        src = 4'b0001;
        tick(2 + SL);
        chk("m_irq", cpu_irq, 1);
        chk("m_id", irq_id, 0);
        mask = 4'b1110;
        tick(1);
        chk("m_drop_irq", cpu_irq, 0);
        chk("m_keep_pend", pending, 4'b0001);
        chk("m_idle", busy, 0);
        tick(2);
        chk("m_stay_off", cpu_irq, 0);
        mask = 4'hF;
        tick(1);
        chk("m_repres", cpu_irq, 1);
        chk("m_repres_id", irq_id, 0);
        pulse_ack();
        src = 4'b0000;
        tick(1 + SL);
        chk("m_clr_drop", irq_clear, 0);

        // clear timeout with source held high
        src = 4'b0100;
        tick(2 + SL);
        chk("t_irq", cpu_irq, 1);
        pulse_ack();
        chk("t_clr_c1", irq_clear, 4'b0100);
        for (int i = 2; i <= 5; i++) begin
            tick(1);
            chk($sformatf("t_clr_c%0d", i), irq_clear, 4'b0100);
            chk($sformatf("t_err_c%0d", i), clr_err, 0);
        end
        tick(1);
        chk("t_clr_off", irq_clear, 0);
        chk("t_err", clr_err, 1);
        chk("t_idle", busy, 0);
        tick(3);
        chk("t_err_sticky", clr_err, 1);
        chk("t_no_irq", cpu_irq, 0);

        // re-fire of another source during CLEAR, then reset mid-ASSERT
        src = 4'b0000;
        tick(2 + SL);
        src = 4'b0100;
        tick(2 + SL);
        chk("r_irq", cpu_irq, 1);
        chk("r_id", irq_id, 2);
        pulse_ack();
        src = 4'b0101;
        tick(1 + SL);
        chk("r_pend_in_clr", pending, 4'b0001);
        chk("r_clr_held", irq_clear, 4'b0100);
        chk("r_busy", busy, 1);
        src = 4'b0001;
        tick(1 + SL);
        chk("r_clr_drop", irq_clear, 0);
        tick(1);
        chk("r_irq0", cpu_irq, 1);
        chk("r_id0", irq_id, 0);
        rst = 1'b1;
        #1;
        chk("x_irq", cpu_irq, 0);
        chk("x_id", irq_id, 0);
        chk("x_pend", pending, 0);
        chk("x_busy", busy, 0);
        chk("x_err", clr_err, 0);
        chk("x_clr", irq_clear, 0);
        rst = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
